axis_frame_tx: RTL
==================

Name: axis_frame_tx

Overview:
- AXI-Stream master-side frame transmitter; the producer that feeds a stream-slave memory write port.
- Buffers words from a local valid/ready port in an internal FIFO.
- Emits them as fixed-length AXI-Stream frames: tlast on the final beat, full tstrb on every beat, honouring tready backpressure.

Parameters:
- DATA_WIDTH, 32, tdata and local data width (multiple of 8)
- FIFO_DEPTH, 16, FIFO entries (power of 2)
- FIFO_AW, 4, log2(FIFO_DEPTH)
- LEN_WIDTH, 12, width of frame_len and beat counter

Ports:
- m01_axis_aclk  in  1  single clock
- m01_axis_areset  in  1  reset; synchronous and active-high
- in_data  in  DATA_WIDTH  local write data
- in_valid  in  1  local write strobe
- in_ready  out  1  FIFO can accept a word
- enable  in  1  permit start of a new frame
- frame_len  in  LEN_WIDTH  beats per frame, sampled at frame start
- m01_axis_tdata  out  DATA_WIDTH  stream data
- m01_axis_tstrb  out  DATA_WIDTH/8  byte strobes
- m01_axis_tvalid  out  1  beat valid
- m01_axis_tlast  out  1  final beat of frame
- m01_axis_tready  in  1  downstream ready
- fifo_count  out  FIFO_AW+1  current FIFO occupancy
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse on last-beat handshake

Behaviour:
- Reset (sync, active-high):
  - All outputs 0: tdata, tstrb, tvalid, tlast, busy, frame_done.
  - FIFO empty; fifo_count=0; in_ready=1 in the first cycle after reset.
  - State goes to IDLE; beat counter 0.
- Reset mid-frame abandons the frame. tvalid drops at that edge; downstream is reset alongside.
- FIFO write and in_ready:
  - in_ready = (fifo_count < FIFO_DEPTH), combinational from the registered count.
  - A word is written on any edge with in_valid && in_ready.
  - When full, in_ready=0 and the write is refused, even if a read occurs in the same cycle (no pass-through).
- Simultaneous FIFO write and read: count unchanged; pointers wrap modulo FIFO_DEPTH.
- Output register loads from the FIFO head when all hold:
  - state=SEND
  - FIFO non-empty
  - output register free, i.e. (!tvalid || tready)
- Load effects:
  - tdata <= head; tstrb <= all ones; tvalid <= 1; beat_cnt increments.
  - tlast <= 1 iff the load is beat number len-1.
- When the register is free and no load occurs, tvalid <= 0.
- Hold rule: while tvalid && !tready, tdata, tstrb and tlast are held stable.
- State machine:
  - IDLE: if enable=1, latch len = frame_len (0 treated as 1), clear beat_cnt, go to SEND.
  - SEND: load beats as above. The load that sets tlast moves the FSM to DRAIN.
  - DRAIN: on tvalid && tready && tlast, pulse frame_done for one cycle, clear tvalid (no new load), go to IDLE.
- Changes to frame_len or enable during SEND or DRAIN are ignored; a frame in progress always completes.
- Latency: with FSM in SEND, a word accepted at edge N appears on tvalid/tdata after edge N+1.
- Back-to-back frames: at least a 1-cycle tvalid gap (DRAIN→IDLE→SEND).
- An empty FIFO during SEND inserts tvalid=0 bubbles; the frame continues when data arrives.
- Width rules:
  - beat_cnt is LEN_WIDTH bits; maximum frame is 2^LEN_WIDTH-1 beats.
  - fifo_count is FIFO_AW+1 bits, reaching FIFO_DEPTH when full.

Optional Feature:
- Macro: FRAME_TX_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit).
  - flush=1 in SEND sets flush_pending.
  - The next beat loaded while pending carries tlast=1 regardless of beat_cnt; the FSM goes to DRAIN and flush_pending clears.
  - flush in IDLE or DRAIN is ignored.
  - No zero-length frames: flush with FIFO empty waits for the next word.
- Not defined: no flush port; frames end only at len beats.

Test Plan:
- Reset, frame_len=4, enable=1, write 0x11,0x22,0x33,0x44, tready=1 → four beats with tstrb=0xF; tlast only on 0x44; frame_done pulses once; busy returns to 0.
- Fill FIFO with 16 words while tready=0 → in_ready=0, fifo_count=16; 17th write refused; after tready=1, exactly 16 words are output in order.
- frame_len=3, tready toggled 1,0,0,1 during frame → tdata and tlast stable throughout each stall; no beat duplicated or lost.
- frame_len=0 → single-beat frame with tlast=1.
- frame_len=2, 5 words queued → frames [w0,w1], [w2,w3] with a tvalid gap between; w4 waits; changing frame_len mid-frame has no effect.
- FRAME_TX_FLUSH_EN: frame_len=8, 3 words queued, flush pulsed after beat 1 → beat 2 (third word) carries tlast=1; frame_done pulses.
- Assert reset during beat 2 → tvalid=0 and fifo_count=0 the next cycle.

Source files
------------

// File: rtl/axis_frame_tx.sv
// AXI-Stream frame transmitter: local words go through a FIFO and leave as fixed-length frames.
// Define FRAME_TX_FLUSH_EN to add a flush input that ends the current frame early.
module axis_frame_tx #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FIFO_AW    = 4,
    parameter int unsigned LEN_WIDTH  = 12
) (
    input  logic                    m01_axis_aclk,
    input  logic                    m01_axis_areset,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    enable,
    input  logic [LEN_WIDTH-1:0]    frame_len,
`ifdef FRAME_TX_FLUSH_EN
    input  logic                    flush,
`endif
    output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
    output logic                    m01_axis_tvalid,
    output logic                    m01_axis_tlast,
    input  logic                    m01_axis_tready,
    output logic [FIFO_AW:0]        fifo_count,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int unsigned CNT_W = FIFO_AW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_n;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]    wr_ptr;
    logic [FIFO_AW-1:0]    rd_ptr;
    logic [LEN_WIDTH-1:0]  len;
    logic [LEN_WIDTH-1:0]  beat_cnt;
    logic                  wr_en;
    logic                  load;
    logic                  last_load;
    logic                  last_done;
    logic                  flush_hit;

    // Full FIFO refuses writes even when a read happens the same cycle.
    assign in_ready  = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign wr_en     = in_valid && in_ready;
    assign load      = (state == ST_SEND) && (fifo_count != '0) &&
                       (!m01_axis_tvalid || m01_axis_tready);
    assign last_load = load && ((beat_cnt == len - LEN_WIDTH'(1)) || flush_hit);
    assign last_done = (state == ST_DRAIN) && m01_axis_tvalid &&
                       m01_axis_tready && m01_axis_tlast;

`ifdef FRAME_TX_FLUSH_EN
    logic flush_pending;

    // A flush request survives until the next loaded beat, which then closes the frame.
    always_ff @(posedge m01_axis_aclk) begin
        if (m01_axis_areset) begin
            flush_pending <= 1'b0;
        end else begin
            flush_pending <= (state == ST_SEND) && !last_load && (flush_pending || flush);
        end
    end

    assign flush_hit = flush_pending;
`else
    assign flush_hit = 1'b0;
`endif

    always_ff @(posedge m01_axis_aclk) begin
        if (m01_axis_areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (enable)    state_n = ST_SEND;
            ST_SEND:  if (last_load) state_n = ST_DRAIN;
            ST_DRAIN: if (last_done) state_n = ST_IDLE;
            default:                 state_n = ST_IDLE;
        endcase
    end

    // Storage has no reset; validity is tracked by the pointers and count.
    always_ff @(posedge m01_axis_aclk) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge m01_axis_aclk) begin
        if (m01_axis_areset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fifo_count      <= '0;
            len             <= '0;
            beat_cnt        <= '0;
            m01_axis_tdata  <= '0;
            m01_axis_tstrb  <= '0;
            m01_axis_tvalid <= 1'b0;
            m01_axis_tlast  <= 1'b0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
        end else begin
            frame_done <= last_done;
            busy       <= (state_n != ST_IDLE);
            fifo_count <= fifo_count + CNT_W'(wr_en) - CNT_W'(load);
            if (wr_en) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if ((state == ST_IDLE) && enable) begin
                len      <= (frame_len == '0) ? LEN_WIDTH'(1) : frame_len;
                beat_cnt <= '0;
            end
            // Output register: load when free, otherwise hold or go idle.
            if (load) begin
                m01_axis_tdata  <= mem[rd_ptr];
                m01_axis_tstrb  <= '1;
                m01_axis_tvalid <= 1'b1;
                m01_axis_tlast  <= last_load;
                rd_ptr          <= rd_ptr + FIFO_AW'(1);
                beat_cnt        <= beat_cnt + LEN_WIDTH'(1);
            end else if (!m01_axis_tvalid || m01_axis_tready) begin
                m01_axis_tvalid <= 1'b0;
                m01_axis_tlast  <= 1'b0;
            end
        end
    end

endmodule
